// File: rtl/eq_serial_ctrl.sv
// Bit-serial equality sequencer: time-shares one external 1-bit XNOR cell
// across WIDTH-bit operands, LSB first, reporting eq and the lowest mismatch index.
//
// state  | meaning
// S_IDLE | waiting for start; operands captured on an accepted start
// S_RUN  | one bit pair presented to the eq cell per cycle
// S_DONE | one-cycle done pulse, eq/first_mis valid
module eq_serial_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     cmp_b1,
    output logic                     cmp_b2,
    input  logic                     cmp_out,
    output logic                     busy,
    output logic                     done,
    output logic                     eq,
    output logic [$clog2(WIDTH)-1:0] first_mis
);

    localparam int            IW       = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [IW-1:0]   idx;
    logic            mis_found;
    logic [IW-1:0]   mis_idx;
    logic            mis_found_next;
    logic [IW-1:0]   mis_idx_next;
    logic            run_last;

    // The cell result is only meaningful while RUN presents a bit pair.
    assign cmp_b1 = (state == S_RUN) ? sa[0] : 1'b0;
    assign cmp_b2 = (state == S_RUN) ? sb[0] : 1'b0;

    // Only the first mismatch is recorded; later ones leave the index alone.
    assign mis_found_next = mis_found | ~cmp_out;
    assign mis_idx_next   = (!mis_found && !cmp_out) ? idx : mis_idx;
    assign run_last       = (idx == LAST_IDX) || (EARLY_EXIT && !cmp_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sa        <= '0;
            sb        <= '0;
            idx       <= '0;
            mis_found <= 1'b0;
            mis_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eq        <= 1'b0;
            first_mis <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa        <= a;
                        sb        <= b;
                        idx       <= '0;
                        mis_found <= 1'b0;
                        mis_idx   <= '0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    sa        <= sa >> 1;
                    sb        <= sb >> 1;
                    mis_found <= mis_found_next;
                    mis_idx   <= mis_idx_next;
                    if (run_last) begin
                        // Results land together with the done pulse.
                        done      <= 1'b1;
                        eq        <= ~mis_found_next;
                        first_mis <= mis_idx_next;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Bench for eq_serial_ctrl: one early-exit and one full-scan instance driven in
// parallel, each with its own model of the shared XNOR cell.
module tb_eq_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic       b1_e, b2_e, out_e, busy_e, done_e, eq_e;
    logic [2:0] mis_e;
    logic       b1_f, b2_f, out_f, busy_f, done_f, eq_f;
    logic [2:0] mis_f;

    assign out_e = ~(b1_e ^ b2_e);
    assign out_f = ~(b1_f ^ b2_f);

    always #5 clk = ~clk;

    eq_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .cmp_b1(b1_e), .cmp_b2(b2_e), .cmp_out(out_e),
        .busy(busy_e), .done(done_e), .eq(eq_e), .first_mis(mis_e)
    );

    eq_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .cmp_b1(b1_f), .cmp_b2(b2_f), .cmp_out(out_f),
        .busy(busy_f), .done(done_f), .eq(eq_f), .first_mis(mis_f)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       eq;
        logic [2:0] mis;
        int         lat_ee;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] sb1, sb2;
        logic       r_eq_e, r_eq_f, prev_eq;
        logic [2:0] r_mis_e, r_mis_f, prev_mis;
        int         bad_e, bad_f, bad;

        vecs[0] = '{8'hA5, 8'hA5, 1'b1, 3'd0, 8};
        vecs[1] = '{8'hA5, 8'hA4, 1'b0, 3'd0, 1};
        vecs[2] = '{8'h00, 8'h80, 1'b0, 3'd7, 8};
        vecs[3] = '{8'h0F, 8'h00, 1'b0, 3'd0, 1};
        vecs[4] = '{8'h3C, 8'h34, 1'b0, 3'd3, 4};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 3'd0, 8};
        vecs[6] = '{8'h5A, 8'h7A, 1'b0, 3'd5, 6};
        vecs[7] = '{8'h60, 8'hA0, 1'b0, 3'd6, 7};

        // Reset state
        #3;
        chk("rst_busy", {busy_e, busy_f}, 2'b00);
        chk("rst_done", {done_e, done_f}, 2'b00);
        chk("rst_eq", {eq_e, eq_f}, 2'b00);
        chk("rst_mis", {mis_e, mis_f}, 6'd0);
        chk("rst_cmp", {b1_e, b2_e, b1_f, b2_f}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        prev_eq = 1'b0;
        prev_mis = 3'd0;
        foreach (vecs[v]) begin
            @(negedge clk);
            chk($sformatf("v%0d_hold", v), {eq_e, mis_e, eq_f, mis_f},
                {prev_eq, prev_mis, prev_eq, prev_mis});
            a = vecs[v].a;
            b = vecs[v].b;
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            bad_e = 0; bad_f = 0;
            sb1 = '0; sb2 = '0;
            r_eq_e = 1'bx; r_eq_f = 1'bx; r_mis_e = 3'bx; r_mis_f = 3'bx;
            for (int n = 0; n < 10; n++) begin
                if (n > 0) @(negedge clk);
                if (n < 8) begin
                    sb1[n] = b1_f;
                    sb2[n] = b2_f;
                end
                if (done_f !== (n == 8)) bad_f++;
                if (busy_f !== (n <= 8)) bad_f++;
                if (done_e !== (n == vecs[v].lat_ee)) bad_e++;
                if (busy_e !== (n <= vecs[v].lat_ee)) bad_e++;
                if (done_e === 1'b1) begin r_eq_e = eq_e; r_mis_e = mis_e; end
                if (done_f === 1'b1) begin r_eq_f = eq_f; r_mis_f = mis_f; end
            end
            chk($sformatf("v%0d_timing_full", v), bad_f, 0);
            chk($sformatf("v%0d_timing_ee", v), bad_e, 0);
            chk($sformatf("v%0d_cmp_b1_seq", v), sb1, vecs[v].a);
            chk($sformatf("v%0d_cmp_b2_seq", v), sb2, vecs[v].b);
            chk($sformatf("v%0d_eq_full", v), r_eq_f, vecs[v].eq);
            chk($sformatf("v%0d_eq_ee", v), r_eq_e, vecs[v].eq);
            chk($sformatf("v%0d_mis_full", v), r_mis_f, vecs[v].mis);
            chk($sformatf("v%0d_mis_ee", v), r_mis_e, vecs[v].mis);
            prev_eq = vecs[v].eq;
            prev_mis = vecs[v].mis;
        end

        // Start re-pulsed mid-RUN with new operands; next start at first IDLE edge
        @(negedge clk);
        a = 8'h33; b = 8'h33; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        for (int n = 1; n < 20; n++) begin
            @(negedge clk);
            if (n == 2) begin start = 1'b1; a = 8'h00; b = 8'hFF; end
            if (n == 3) start = 1'b0;
            if (n == 8) begin
                chk("restart_done", {done_e, done_f}, 2'b11);
                chk("restart_eq", {eq_e, eq_f}, 2'b11);
                start = 1'b1; a = 8'h01; b = 8'h00;
            end
            if (n == 9) chk("restart_idle", {busy_e, done_e, busy_f}, 3'b000);
            if (n == 10) begin
                chk("restart_accept", {busy_e, busy_f}, 2'b11);
                start = 1'b0;
            end
            if (n == 11) chk("restart_next_ee", {done_e, eq_e, mis_e}, {1'b1, 1'b0, 3'd0});
            if (n == 18) chk("restart_next_full", {done_f, eq_f, mis_f}, {1'b1, 1'b0, 3'd0});
            if (n != 8 && n != 11 && done_e) bad++;
            if (n != 8 && n != 18 && done_f) bad++;
        end
        chk("restart_no_extra_done", bad, 0);

        // start held high: back-to-back compares, one IDLE cycle between them
        @(negedge clk);
        a = 8'hA5; b = 8'hA5; start = 1'b1;
        @(posedge clk);
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done_f !== (n == 8 || n == 18)) bad++;
            if (done_e !== (n == 8 || n == 18)) bad++;
        end
        start = 1'b0;
        chk("hold_start_dones", bad, 0);
        chk("hold_start_eq", {eq_e, eq_f}, 2'b11);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_cmp", {b1_f, b2_f, busy_f}, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", {busy_e, busy_f}, 2'b00);
        chk("midrun_rst_eq_done", {eq_e, eq_f, done_e, done_f}, 4'd0);
        chk("midrun_rst_cmp", {b1_e, b2_e, b1_f, b2_f}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h01; b = 8'h00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("post_rst_accept", {busy_e, busy_f, done_e, done_f}, 4'b1100);
        @(negedge clk);
        chk("post_rst_ee_done", {done_e, eq_e, mis_e}, {1'b1, 1'b0, 3'd0});
        repeat (9) @(negedge clk);
        chk("post_rst_idle", {busy_e, busy_f}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
